// File: rtl/hdmi_timing_rx.sv
// HDMI sink-side timing receiver: measures line/frame timing against expected values,
// declares lock after consecutive good frames and tags active pixels with x/y coordinates.
module hdmi_timing_rx #(
    parameter logic [11:0] EXP_H_TOTAL  = 12'd2200,
    parameter logic [11:0] EXP_H_ACTIVE = 12'd1920,
    parameter logic [11:0] EXP_V_TOTAL  = 12'd1125,
    parameter logic [11:0] EXP_V_ACTIVE = 12'd1080,
    parameter logic [2:0]  LOCK_FRAMES  = 3'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic        data_en,
    input  logic [23:0] data,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_error,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_v_total
);

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_t;

    state_t      state_q;
    logic        hs_s1, vs_s1, de_s1;
    logic        hs_s2, vs_s2, de_s2;
    logic [23:0] data_s1;
    logic [11:0] hcnt_q, hact_q, vcnt_q, vact_q, px_q, py_q;
    logic        hovf_q;
    logic        lines_ok_q;
    logic        first_line_q;
    logic [2:0]  good_q;

    logic        h_rise, v_rise, de_rise, de_fall;
    logic [11:0] px_cur, py_cur, vcnt_tot;
    logic        line_chk, line_ok, line_bad, frame_ok;
    logic [2:0]  good_inc;

    always_comb begin
        h_rise   = hs_s1 & ~hs_s2;
        v_rise   = vs_s1 & ~vs_s2;
        de_rise  = de_s1 & ~de_s2;
        de_fall  = ~de_s1 & de_s2;
        px_cur   = de_rise ? 12'd0 : px_q;
        py_cur   = v_rise ? 12'd0 : py_q;
        // The h_rise coinciding with v_rise closes the last line of the ending frame.
        vcnt_tot = (h_rise && vcnt_q != 12'hfff) ? vcnt_q + 12'd1 : vcnt_q;
        // The first line after leaving search started before we were watching.
        line_chk = h_rise && (state_q != StSearch) && !first_line_q;
        line_ok  = (hcnt_q == EXP_H_TOTAL) && !hovf_q &&
                   ((hact_q == 12'd0) || (hact_q == EXP_H_ACTIVE));
        line_bad = line_chk && !line_ok;
        frame_ok = (vcnt_tot == EXP_V_TOTAL) && (vact_q == EXP_V_ACTIVE) &&
                   lines_ok_q && !line_bad;
        good_inc = good_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StSearch;
            hs_s1        <= 1'b0;
            vs_s1        <= 1'b0;
            de_s1        <= 1'b0;
            hs_s2        <= 1'b0;
            vs_s2        <= 1'b0;
            de_s2        <= 1'b0;
            data_s1      <= '0;
            hcnt_q       <= '0;
            hact_q       <= '0;
            vcnt_q       <= '0;
            vact_q       <= '0;
            px_q         <= '0;
            py_q         <= '0;
            hovf_q       <= 1'b0;
            lines_ok_q   <= 1'b0;
            first_line_q <= 1'b1;
            good_q       <= '0;
            pixel_valid  <= 1'b0;
            pixel_data   <= '0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            timing_error <= 1'b0;
            meas_h_total <= '0;
            meas_v_total <= '0;
        end else begin
            hs_s1   <= h_sync;
            vs_s1   <= v_sync;
            de_s1   <= data_en;
            data_s1 <= data;
            hs_s2   <= hs_s1;
            vs_s2   <= vs_s1;
            de_s2   <= de_s1;

            pixel_valid <= de_s1;
            pixel_data  <= data_s1;
            pixel_x     <= px_cur;
            pixel_y     <= py_cur;
            frame_start <= de_s1 && (px_cur == 12'd0) && (py_cur == 12'd0);
            px_q        <= de_s1 ? px_cur + 12'd1 : px_cur;
            py_q        <= de_fall ? py_cur + 12'd1 : py_cur;

            if (h_rise) begin
                hcnt_q       <= 12'd1;
                hovf_q       <= 1'b0;
                hact_q       <= {11'd0, de_s1};
                meas_h_total <= hcnt_q;
            end else begin
                if (hcnt_q != 12'hfff) hcnt_q <= hcnt_q + 12'd1;
                else                   hovf_q <= 1'b1;
                if (de_s1 && hact_q != 12'hfff) hact_q <= hact_q + 12'd1;
            end

            if (v_rise) begin
                vcnt_q       <= 12'd0;
                vact_q       <= {11'd0, de_fall};
                meas_v_total <= vcnt_tot;
                lines_ok_q   <= 1'b1;
            end else begin
                vcnt_q <= vcnt_tot;
                if (de_fall && vact_q != 12'hfff) vact_q <= vact_q + 12'd1;
                if (line_bad) lines_ok_q <= 1'b0;
            end

            timing_error <= 1'b0;
            if (h_rise) first_line_q <= 1'b0;

            case (state_q)
                StSearch: begin
                    if (v_rise) begin
                        state_q      <= StMeasure;
                        good_q       <= 3'd0;
                        first_line_q <= ~h_rise;
                    end else begin
                        first_line_q <= 1'b1;
                    end
                end
                StMeasure: begin
                    if (v_rise) begin
                        if (frame_ok) begin
                            good_q <= good_inc;
                            if (good_inc == LOCK_FRAMES) begin
                                state_q <= StLocked;
                                locked  <= 1'b1;
                            end
                        end else begin
                            good_q       <= 3'd0;
                            timing_error <= 1'b1;
                        end
                    end
                end
                StLocked: begin
                    if (line_bad || (v_rise && !frame_ok)) begin
                        state_q      <= StMeasure;
                        locked       <= 1'b0;
                        good_q       <= 3'd0;
                        timing_error <= 1'b1;
                    end
                end
                default: state_q <= StSearch;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_timing_rx.sv
// Directed bench for hdmi_timing_rx with a small 40x12 raster (26x7 active, lock after 2 frames).
module tb_hdmi_timing_rx;

    localparam int HT = 40;
    localparam int HA = 26;
    localparam int VA = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        h_sync = 1'b0;
    logic        v_sync = 1'b0;
    logic        data_en = 1'b0;
    logic [23:0] data = '0;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        frame_start;
    logic        locked;
    logic        timing_error;
    logic [11:0] meas_h_total;
    logic [11:0] meas_v_total;

    always #5 clk = ~clk;

    hdmi_timing_rx #(
        .EXP_H_TOTAL (12'd40),
        .EXP_H_ACTIVE(12'd26),
        .EXP_V_TOTAL (12'd12),
        .EXP_V_ACTIVE(12'd7),
        .LOCK_FRAMES (3'd2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .data_en     (data_en),
        .data        (data),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .locked      (locked),
        .timing_error(timing_error),
        .meas_h_total(meas_h_total),
        .meas_v_total(meas_v_total)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Previous-tick stimulus: outputs sampled after a tick reflect the tick before it.
    logic        prev_de = 1'b0;
    logic [23:0] prev_data = '0;
    int          prev_x = 0;
    int          prev_y = 0;
    bit          pix_chk = 1'b0;
    logic        locked_prev = 1'b0;
    int          te_frame;
    int          lock_tick;
    int          te_at[12];
    int          meas_at[12];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " pixel_valid"}, int'(pixel_valid), 0);
        check({tag, " pixel_data"}, int'(pixel_data), 0);
        check({tag, " pixel_x"}, int'(pixel_x), 0);
        check({tag, " pixel_y"}, int'(pixel_y), 0);
        check({tag, " frame_start"}, int'(frame_start), 0);
        check({tag, " locked"}, int'(locked), 0);
        check({tag, " timing_error"}, int'(timing_error), 0);
        check({tag, " meas_h_total"}, int'(meas_h_total), 0);
        check({tag, " meas_v_total"}, int'(meas_v_total), 0);
    endtask

    task automatic tick(input logic hs, input logic vs, input logic de, input logic [23:0] d,
                        input int ex, input int ey);
        h_sync  = hs;
        v_sync  = vs;
        data_en = de;
        data    = d;
        @(posedge clk);
        #1;
        if (pix_chk) begin
            check("pixel_valid", int'(pixel_valid), int'(prev_de));
            check("frame_start", int'(frame_start),
                  (prev_de && prev_x == 0 && prev_y == 0) ? 1 : 0);
            if (prev_de) begin
                check("pixel_data", int'(pixel_data), int'(prev_data));
                check("pixel_x", int'(pixel_x), prev_x);
                check("pixel_y", int'(pixel_y), prev_y);
            end
        end
        prev_de   = de;
        prev_data = d;
        prev_x    = ex;
        prev_y    = ey;
    endtask

    // One frame: v_sync on lines 0-1, h_sync on clocks 0-3, active on lines 2-8, clocks 8-33.
    task automatic run_frame(input int nlines, input int long_line, input int long_len,
                             input int rst_tick, input bit pc);
        int t;
        int len;
        logic de;
        t         = 0;
        pix_chk   = pc;
        te_frame  = 0;
        lock_tick = -1;
        for (int l = 0; l < nlines; l++) begin
            len = (l == long_line) ? long_len : HT;
            for (int p = 0; p < len; p++) begin
                if (t == rst_tick) begin
                    rst = 1'b0;
                    #1;
                    check_zero("async reset");
                end
                de = (l >= 2) && (l < 2 + VA) && (p >= 8) && (p < 8 + HA);
                tick(p < 4, l < 2, de, 24'($urandom()), p - 8, l - 2);
                if (t == rst_tick) rst = 1'b1;
                if (timing_error) te_frame++;
                if (p == 1) begin
                    te_at[l]   = int'(timing_error);
                    meas_at[l] = int'(meas_h_total);
                end
                if (locked && !locked_prev && lock_tick < 0) lock_tick = t;
                locked_prev = locked;
                t++;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // Clean acquisition: lock at the 3rd v_rise.
        run_frame(12, -1, 0, -1, 1'b0);
        check("f1 lock_tick", lock_tick, -1);
        check("f1 errors", te_frame, 0);
        run_frame(12, -1, 0, -1, 1'b0);
        check("f2 lock_tick", lock_tick, -1);
        check("f2 meas_v_total", int'(meas_v_total), 12);
        check("f2 meas_h_total", int'(meas_h_total), 40);
        run_frame(12, -1, 0, -1, 1'b0);
        check("f3 lock_tick", lock_tick, 1);
        check("f3 errors", te_frame, 0);

        // Coordinate and data pass-through frame.
        run_frame(12, -1, 0, -1, 1'b1);
        check("f4 locked", int'(locked), 1);
        check("f4 errors", te_frame, 0);

        // Stretched line 5 (41 clocks): error at the h_rise starting line 6.
        run_frame(12, 5, 41, -1, 1'b0);
        check("stretch meas_h", meas_at[6], 41);
        check("stretch error pulse", te_at[6], 1);
        check("stretch errors in frame", te_frame, 1);
        check("stretch locked", int'(locked), 0);
        run_frame(12, -1, 0, -1, 1'b0);
        check("stretch+1 lock_tick", lock_tick, -1);
        run_frame(12, -1, 0, -1, 1'b0);
        check("stretch+2 lock_tick", lock_tick, -1);
        run_frame(12, -1, 0, -1, 1'b0);
        check("stretch+3 relock", lock_tick, 1);
        check("stretch+3 errors", te_frame, 0);

        // Short frames (11 lines).
        run_frame(11, -1, 0, -1, 1'b0);
        check("short1 errors", te_frame, 0);
        run_frame(12, -1, 0, -1, 1'b0);
        check("short1 error pulse", te_at[0], 1);
        check("short1 errors after", te_frame, 1);
        check("short1 meas_v_total", int'(meas_v_total), 11);
        check("short1 locked", int'(locked), 0);
        run_frame(11, -1, 0, -1, 1'b0);
        check("short2 lock_tick", lock_tick, -1);
        run_frame(12, -1, 0, -1, 1'b0);
        check("short2 error pulse", te_at[0], 1);
        check("short2 locked", int'(locked), 0);
        run_frame(12, -1, 0, -1, 1'b0);
        check("good_cnt reset", lock_tick, -1);
        check("short2+2 errors", te_frame, 0);
        run_frame(12, -1, 0, -1, 1'b0);
        check("short relock", lock_tick, 1);

        // h_sync absent for 5000 clocks on line 10.
        run_frame(12, 10, 5004, -1, 1'b0);
        check("ovf meas_h", meas_at[11], 4095);
        check("ovf error pulse", te_at[11], 1);
        check("ovf errors in frame", te_frame, 1);
        check("ovf locked", int'(locked), 0);
        run_frame(12, -1, 0, -1, 1'b0);
        run_frame(12, -1, 0, -1, 1'b0);
        check("ovf+2 lock_tick", lock_tick, -1);
        run_frame(12, -1, 0, -1, 1'b0);
        check("ovf relock", lock_tick, 1);

        // One-clock reset mid-line 4 while locked, then relock on schedule.
        run_frame(12, -1, 0, 4 * HT + 20, 1'b0);
        check("rst frame locked", int'(locked), 0);
        check("rst frame errors", te_frame, 0);
        run_frame(12, -1, 0, -1, 1'b1);
        check("rst+1 lock_tick", lock_tick, -1);
        check("rst+1 errors", te_frame, 0);
        run_frame(12, -1, 0, -1, 1'b0);
        check("rst+2 lock_tick", lock_tick, -1);
        run_frame(12, -1, 0, -1, 1'b0);
        check("rst relock", lock_tick, 1);
        check("rst+3 errors", te_frame, 0);
        check("rst+3 meas_v_total", int'(meas_v_total), 12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
